// File: rtl/flash_addr_seq.sv
// Flash read address sequencer: windowed wrap/step counter with a req/ack handshake.
// Optional one-shot stop at the window edge via FLASH_ADDR_SEQ_ONESHOT_EN.
module flash_addr_seq #(
   parameter int unsigned       ADDR_W = 23,
   parameter logic [ADDR_W-1:0] START  = '0,
   parameter logic [ADDR_W-1:0] LAST   = 'h7FFFF,
   parameter int unsigned       STEP_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              advance_i,
   input  logic              play_i,
   input  logic              dir_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              restart_i,
   input  logic              oneshot_i,
   input  logic              ack_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              req_o,
   output logic              done_o,
   output logic              overrun_o
);

   localparam logic [ADDR_W:0] START_X = {1'b0, START};
   localparam logic [ADDR_W:0] LAST_X  = {1'b0, LAST};
   localparam logic [ADDR_W:0] SPAN_X  = LAST_X - START_X + 1'b1;

`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_REQ} state_t;
`endif

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_q, pend_q, overrun_q;
   logic [ADDR_W:0]   step_x, addr_x, fwd_sum;
   logic              wrap;

   // Step arithmetic is one bit wider than the address so the wrap compare cannot overflow.
   always_comb begin
      step_x  = {{(ADDR_W+1-STEP_W){1'b0}}, step_i};
      if (step_i == '0) step_x = 1;
      addr_x  = {1'b0, addr_q};
      fwd_sum = addr_x + step_x;
      if (dir_i) begin
         wrap   = fwd_sum > LAST_X;
         addr_d = wrap ? ADDR_W'(fwd_sum - SPAN_X) : ADDR_W'(fwd_sum);
      end else begin
         wrap   = addr_x < START_X + step_x;
         addr_d = wrap ? ADDR_W'(addr_x - step_x + SPAN_X) : ADDR_W'(addr_x - step_x);
      end
`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
      if (oneshot_i && wrap) addr_d = dir_i ? LAST : START;
`endif
   end

`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
   logic clamp, final_q, done_q;
   assign clamp  = oneshot_i && wrap;
   assign done_o = done_q;
`else
   logic unused_oneshot;
   assign unused_oneshot = oneshot_i;
   assign done_o         = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      overrun_q <= 1'b0;
`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
      done_q    <= 1'b0;
`endif
      if (!rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= START;
         req_q   <= 1'b0;
         pend_q  <= 1'b0;
`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
         final_q <= 1'b0;
`endif
      end else if (restart_i) begin
         state_q <= S_IDLE;
         addr_q  <= dir_i ? START : LAST;
         req_q   <= 1'b0;
         pend_q  <= 1'b0;
`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
         final_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (advance_i && play_i) begin
                  addr_q  <= addr_d;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
                  final_q <= clamp;
`endif
               end
            end
            S_REQ: begin
               if (ack_i) begin
`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
                  if (final_q) begin
                     done_q  <= 1'b1;
                     req_q   <= 1'b0;
                     pend_q  <= 1'b0;
                     final_q <= 1'b0;
                     state_q <= S_STOP;
                  end else
`endif
                  // A same-cycle advance counts as a pending step behind this ack.
                  if (play_i && (pend_q || advance_i)) begin
                     addr_q <= addr_d;
                     pend_q <= pend_q && advance_i;
`ifdef FLASH_ADDR_SEQ_ONESHOT_EN
                     final_q <= clamp;
`endif
                  end else begin
                     req_q   <= 1'b0;
                     pend_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end else if (advance_i && play_i) begin
                  if (pend_q) overrun_q <= 1'b1;
                  else        pend_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign addr_o    = addr_q;
   assign req_o     = req_q;
   assign overrun_o = overrun_q;

endmodule
